// File: rtl/wr_resp_sched_if.sv
// B-channel bundle shared by the mux side and the master side
// of the write-response scheduler.
interface wr_resp_sched_if;
  logic [3:0] bid;
  logic [1:0] bresp;
  logic       bvalid;
  logic       bready;

  modport master (
    output bid,
    output bresp,
    output bvalid,
    input  bready
  );

  modport slave (
    input  bid,
    input  bresp,
    input  bvalid,
    output bready
  );
endinterface

// File: rtl/wr_resp_sched.sv
// Write-response scheduler: per-region outstanding tracking,
// round-robin mux select and a 2-entry skid FIFO to the master.
module wr_resp_sched #(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [3:0]     awid,
  input  logic           awvalid,
  input  logic           awready,
  output logic           aw_allow,
  output logic [2:0]     sel,
  wr_resp_sched_if.slave  s_b,
  wr_resp_sched_if.master m00_axi_b,
  output logic           err_unexp,
  output logic           err_ovf
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt [4];
  logic [1:0]       aw_r;
  logic [1:0]       b_r;
  logic [1:0]       sel_q;
  logic [1:0]       sel_d;
  logic [1:0]       idx;
  logic             found;
  logic             aw_fire;
  logic             b_in;
  logic             b_out;
  logic [3:0]       inc;
  logic [3:0]       dec;
  logic [3:0]       busy;
  logic             ovf_hit;
  logic             unexp_hit;
  logic [1:0]       occ;
  logic             wp;
  logic             rp;
  logic [5:0]       mem [2];

  always_comb begin
    aw_fire   = awvalid & awready;
    b_in      = s_b.bvalid & s_b.bready;
    b_out     = m00_axi_b.bvalid & m00_axi_b.bready;
    aw_r      = awid[3:2];
    b_r       = s_b.bid[3:2];
    inc       = '0;
    dec       = '0;
    busy      = '0;
    ovf_hit   = 1'b0;
    unexp_hit = 1'b0;
    for (int r = 0; r < 4; r++) begin
      inc[r]  = aw_fire && (aw_r == 2'(r));
      dec[r]  = b_in && (b_r == 2'(r));
      busy[r] = (cnt[r] != '0) || inc[r];
      if (inc[r] && !dec[r] && cnt[r] == MAX_C)
        ovf_hit = 1'b1;
      if (dec[r] && !inc[r] && cnt[r] == '0)
        unexp_hit = 1'b1;
    end
  end

  assign aw_allow = (cnt[aw_r] != MAX_C);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 4; r++)
        cnt[r] <= '0;
    end else begin
      for (int r = 0; r < 4; r++) begin
        if (inc[r] && !dec[r] && cnt[r] != MAX_C)
          cnt[r] <= cnt[r] + ONE;
        else if (dec[r] && !inc[r] && cnt[r] != '0)
          cnt[r] <= cnt[r] - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_ovf   <= 1'b0;
      err_unexp <= 1'b0;
    end else begin
      if (ovf_hit)
        err_ovf <= 1'b1;
      if (unexp_hit)
        err_unexp <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      sel_q <= '0;
    else
      sel_q <= sel_d;
  end

  // Leave the current region once it is idle or has just been served;
  // it is searched last so the others get a turn first.
  always_comb begin
    sel_d = sel_q;
    found = 1'b0;
    idx   = sel_q;
    if (cnt[sel_q] == '0 || (b_in && b_r == sel_q)) begin
      for (int k = 1; k <= 4; k++) begin
        idx = sel_q + 2'(k);
        if (!found && busy[idx]) begin
          sel_d = idx;
          found = 1'b1;
        end
      end
    end
  end

  assign sel = {1'b0, sel_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ    <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (b_in) begin
        mem[wp] <= {s_b.bid, s_b.bresp};
        wp      <= ~wp;
      end
      if (b_out)
        rp <= ~rp;
      occ <= occ + {1'b0, b_in} - {1'b0, b_out};
    end
  end

  assign s_b.bready       = (occ != 2'd2);
  assign m00_axi_b.bvalid = (occ != 2'd0);
  assign m00_axi_b.bid    = mem[rp][5:2];
  assign m00_axi_b.bresp  = mem[rp][1:0];

endmodule

// File: doc/wr_resp_sched.md
Name: wr_resp_sched

Overview:
Write-response scheduler and buffer for the B channel, sitting directly downstream of the 8-slave write-response mux. It tracks outstanding writes per ID region (awid[3:2]) and drives the mux select, round-robin across regions that have responses owed. Responses the mux returns go into a 2-entry skid FIFO that drives the master B port. It also flags protocol errors: unexpected responses and counter overflow.

Parameters:
MAX_OUT, 4, maximum outstanding writes per region (1..15).
CNT_W, 4, width of each per-region outstanding counter; must hold MAX_OUT.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
awid  input  4  AW ID observed on the master AW channel
awvalid  input  1  AW valid (monitor only)
awready  input  1  AW ready (monitor only, already gated upstream)
aw_allow  output  1  high when region awid[3:2] has room; upstream ANDs this into awready
sel  output  3  region select to the mux; sel[2] always 0
s_bid  input  4  response ID from the mux
s_bresp  input  2  response code from the mux
s_bvalid  input  1  response valid from the mux
s_bready  output  1  ready to the mux
m00_axi_bid  output  4  response ID to the master
m00_axi_bresp  output  2  response code to the master
m00_axi_bvalid  output  1  response valid to the master
m00_axi_bready  input  1  master ready
err_unexp  output  1  sticky: a response arrived for a region with zero outstanding
err_ovf  output  1  sticky: an AW handshake occurred while the region counter was at MAX_OUT

Behaviour:
- Reset (async assert, sync release):
  - cnt[0..3]=0, sel=0, FIFO empty.
  - m00_axi_bvalid=0, m00_axi_bid=0, m00_axi_bresp=0.
  - err_unexp=0, err_ovf=0.
  - s_bready=1 after reset, since the FIFO is empty.
- Reset mid-operation drops all FIFO contents and counters immediately, with no drain.
- aw_fire = awvalid & awready. b_in = s_bvalid & s_bready. b_out = m00_axi_bvalid & m00_axi_bready.
- Counters, for each region r, evaluated per cycle:
  - inc = aw_fire & awid[3:2]==r; dec = b_in & s_bid[3:2]==r.
  - inc & dec: unchanged.
  - inc only: +1. If cnt==MAX_OUT, hold the counter and set err_ovf.
  - dec only: -1. If cnt==0, hold at 0 and set err_unexp; the response is still buffered and forwarded.
- aw_allow = (cnt[awid[3:2]] != MAX_OUT). Combinational.
- Select scheduler (registered sel):
  - Next state is evaluated with the current-cycle counter values.
  - If cnt[sel]==0, or b_in occurred from region sel this cycle: sel moves to the first region r with cnt[r]>0 (or with an inc this cycle), searching sel+1, sel+2, sel+3, sel circularly mod 4.
  - If no region qualifies, sel holds.
  - Otherwise sel holds, so one response is taken per visit, giving fairness.
- Skid FIFO, 2 entries, holding {bid, bresp}:
  - s_bready = (occupancy < 2). It is registered-derived, with no combinational path from m00_axi_bready.
  - Write on b_in; read on b_out. Simultaneous read and write keeps the occupancy.
  - Head entry drives the m00 outputs; m00_axi_bvalid = (occupancy > 0).
  - Latency: 1 cycle from b_in to m00_axi_bvalid when the FIFO was empty.
  - The m00 outputs stay stable while bvalid=1 and bready=0 (AXI rule).
  - Full with bready=0: s_bready=0, and the mux holds its response.
  - Wrap-around: 1-bit read/write pointers plus occupancy counter 0..2.
- Error flags clear only on reset.

Test Plan:
- Single write: AW awid=4'h5, then the mux returns bid=4'h5, bresp=0. Required: cnt[1] goes 1→0; sel=1 when the response arrives; m00_axi_bvalid rises 1 cycle after b_in with bid=5; s_bready stays 1.
- Round-robin: issue AW IDs 0x0, 0x4, 0x8, 0xC with all slaves responding continuously. Required: sel sequence 0,1,2,3 with one accept per region; all counters return to 0; responses reach the master in that order.
- Backpressure: m00_axi_bready=0 and 3 responses offered. Required: FIFO fills with 2, s_bready=0 on the third, head bid held stable. Release bready for 3 cycles: 3 responses out in order, no loss or duplicates.
- Overflow: MAX_OUT=4, issue 4 AWs to region 2. Required: aw_allow=0 for awid=0x8; a forced 5th aw_fire sets err_ovf=1 and cnt[2] stays 4.
- Unexpected response: s_bvalid with bid=0xC while cnt[3]=0. Required: err_unexp=1 (sticky), response still forwarded, cnt[3]=0.
- Reset mid-burst: with 2 responses buffered and cnt[0]=3, assert reset_n=0. Required: m00_axi_bvalid=0 and counters 0 immediately (asynchronous), sel=0, flags 0.
